// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous SRAM among NUM_REQ
// requesters, with lock-based burst ownership bounded by MAX_HOLD.
module sram_port_arbiter #(
   parameter int NUM_REQ    = 3,
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_HOLD   = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ-1:0]            lock,
   input  logic [NUM_REQ-1:0]            we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
   output logic [NUM_REQ-1:0]            gnt,
   output logic [NUM_REQ-1:0]            rvalid,
   output logic [DATA_WIDTH-1:0]         rdata,
   output logic                          mem_cs,
   output logic                          mem_we,
   output logic [ADDR_WIDTH-1:0]         mem_addr,
   output logic [DATA_WIDTH-1:0]         mem_din,
   input  logic [DATA_WIDTH-1:0]         mem_dout
);

   localparam int PW = $clog2(NUM_REQ);
   localparam int HW = $clog2(MAX_HOLD);
   localparam logic [PW-1:0] LAST_REQ = PW'(NUM_REQ - 1);
   localparam logic [HW-1:0] HOLD_TOP = HW'(MAX_HOLD - 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] OWN  = 1'b1;

   logic [0:0]         state, state_nxt;
   logic [PW-1:0]      owner, owner_nxt;
   logic [PW-1:0]      rr_ptr, rr_ptr_nxt;
   logic [HW-1:0]      hold_cnt, hold_nxt;
   logic [NUM_REQ-1:0] gnt_nxt;
   logic               access;
   logic               others;
   logic               keep;
   logic               win_found;
   logic [PW-1:0]      win_idx;
   int                 cand;

   // An access needs both the registered grant and a still-asserted request.
   assign access = |(gnt & req);
   assign others = |(req & ~gnt);
   assign rdata  = mem_dout;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
      mem_cs   = access;
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_din  = '0;
      if (access) begin
         mem_we   = we[owner];
         mem_addr = addr[int'(owner)*ADDR_WIDTH +: ADDR_WIDTH];
         mem_din  = wdata[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Scan from rr_ptr+1 upward with wrap; the current owner is the last candidate.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = (int'(rr_ptr) + k) % NUM_REQ;
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = PW'(cand);
         end
      end
   end

   assign keep = (state == OWN) && req[owner] && lock[owner] &&
                 ((hold_cnt < HOLD_TOP) || !others);

   always_comb begin
      state_nxt  = state;
      owner_nxt  = owner;
      rr_ptr_nxt = rr_ptr;
      hold_nxt   = hold_cnt;
      gnt_nxt    = gnt;
      if (keep) begin
         hold_nxt = (hold_cnt == HOLD_TOP) ? hold_cnt : hold_cnt + 1'b1;
      end else if (win_found) begin
         state_nxt        = OWN;
         owner_nxt        = win_idx;
         rr_ptr_nxt       = win_idx;
         hold_nxt         = '0;
         gnt_nxt          = '0;
         gnt_nxt[win_idx] = 1'b1;
      end else begin
         state_nxt = IDLE;
         hold_nxt  = '0;
         gnt_nxt   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         owner    <= '0;
         rr_ptr   <= LAST_REQ;
         hold_cnt <= '0;
         gnt      <= '0;
         rvalid   <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state    <= state_nxt;
         owner    <= owner_nxt;
         rr_ptr   <= rr_ptr_nxt;
         hold_cnt <= hold_nxt;
         gnt      <= gnt_nxt;
         rvalid   <= (access && !mem_we) ? gnt : '0;
      end
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed, table-driven bench for sram_port_arbiter with a small behavioural
// SRAM model; expected values are hand-computed per cycle.
module tb_sram_port_arbiter;

   logic        clk;
   logic        rst_n;
   logic [2:0]  req, lock, we;
   logic [11:0] addr;
   logic [23:0] wdata;
   logic [2:0]  gnt, rvalid;
   logic [7:0]  rdata;
   logic        mem_cs, mem_we;
   logic [3:0]  mem_addr;
   logic [7:0]  mem_din, mem_dout;

   int total = 0;
   int bad   = 0;

   sram_port_arbiter #(
      .NUM_REQ(3), .ADDR_WIDTH(4), .DATA_WIDTH(8), .MAX_HOLD(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .we(we),
      .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
      .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_dout(mem_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM model: word a holds 8'hC0|a while in reset; one-cycle read latency.
   logic [7:0] sram [16];
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) sram[i] <= 8'hC0 | 8'(i);
      end else if (mem_cs) begin
         if (mem_we) sram[mem_addr] <= mem_din;
         else        mem_dout <= sram[mem_addr];
      end
   end

   // Requester 0 always uses addr 1 / data 11, requester 2 addr 3 / data 33.
   typedef struct {
      logic [2:0] req, lock, we;
      logic [3:0] a1;
      logic [7:0] w1;
      logic [2:0] e_gnt;
      logic       e_cs, e_we;
      logic [3:0] e_addr;
      logic [7:0] e_din;
      logic [2:0] e_rv;
      logic [7:0] e_rdata;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input string tag, input vec_t v);
      @(negedge clk);
      req   = v.req;
      lock  = v.lock;
      we    = v.we;
      addr  = {4'h3, v.a1, 4'h1};
      wdata = {8'h33, v.w1, 8'h11};
      #1;
      check({tag, " gnt"},      32'(gnt),      32'(v.e_gnt));
      check({tag, " mem_cs"},   32'(mem_cs),   32'(v.e_cs));
      check({tag, " mem_we"},   32'(mem_we),   32'(v.e_we));
      check({tag, " mem_addr"}, 32'(mem_addr), 32'(v.e_addr));
      check({tag, " mem_din"},  32'(mem_din),  32'(v.e_din));
      check({tag, " rvalid"},   32'(rvalid),   32'(v.e_rv));
      if (v.e_rv != 3'b000) check({tag, " rdata"}, 32'(rdata), 32'(v.e_rdata));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      //             req     lock    we      a1     w1      gnt     cs    we    addr   din     rv      rdata
      vecs[0]  = '{3'b111, 3'b000, 3'b000, 4'h2, 8'h22, 3'b000, 1'b0, 1'b0, 4'h0, 8'h00, 3'b000, 8'h00};
      vecs[1]  = '{3'b111, 3'b000, 3'b000, 4'h2, 8'h22, 3'b001, 1'b1, 1'b0, 4'h1, 8'h11, 3'b000, 8'h00};
      vecs[2]  = '{3'b111, 3'b000, 3'b000, 4'h2, 8'h22, 3'b010, 1'b1, 1'b0, 4'h2, 8'h22, 3'b001, 8'hC1};
      vecs[3]  = '{3'b111, 3'b000, 3'b000, 4'h2, 8'h22, 3'b100, 1'b1, 1'b0, 4'h3, 8'h33, 3'b010, 8'hC2};
      vecs[4]  = '{3'b111, 3'b000, 3'b000, 4'h2, 8'h22, 3'b001, 1'b1, 1'b0, 4'h1, 8'h11, 3'b100, 8'hC3};
      vecs[5]  = '{3'b000, 3'b000, 3'b000, 4'h2, 8'h22, 3'b010, 1'b0, 1'b0, 4'h0, 8'h00, 3'b001, 8'hC1};
      vecs[6]  = '{3'b000, 3'b000, 3'b000, 4'h2, 8'h22, 3'b000, 1'b0, 1'b0, 4'h0, 8'h00, 3'b000, 8'h00};
      vecs[7]  = '{3'b010, 3'b000, 3'b010, 4'h7, 8'hA5, 3'b000, 1'b0, 1'b0, 4'h0, 8'h00, 3'b000, 8'h00};
      vecs[8]  = '{3'b010, 3'b000, 3'b010, 4'h7, 8'hA5, 3'b010, 1'b1, 1'b1, 4'h7, 8'hA5, 3'b000, 8'h00};
      vecs[9]  = '{3'b010, 3'b000, 3'b000, 4'h7, 8'hA5, 3'b010, 1'b1, 1'b0, 4'h7, 8'hA5, 3'b000, 8'h00};
      vecs[10] = '{3'b000, 3'b000, 3'b000, 4'h7, 8'hA5, 3'b010, 1'b0, 1'b0, 4'h0, 8'h00, 3'b010, 8'hA5};
      vecs[11] = '{3'b000, 3'b000, 3'b000, 4'h7, 8'hA5, 3'b000, 1'b0, 1'b0, 4'h0, 8'h00, 3'b000, 8'h00};

      rst_n = 1'b0;
      req   = '0;
      lock  = '0;
      we    = '0;
      addr  = '0;
      wdata = '0;
      repeat (2) @(negedge clk);
      #1;
      check("reset gnt",      32'(gnt),      32'h0);
      check("reset rvalid",   32'(rvalid),   32'h0);
      check("reset mem_cs",   32'(mem_cs),   32'h0);
      check("reset mem_we",   32'(mem_we),   32'h0);
      check("reset mem_addr", 32'(mem_addr), 32'h0);
      check("reset mem_din",  32'(mem_din),  32'h0);
      rst_n = 1'b1;

      // Round-robin under full contention, then lone write/read by requester 1.
      for (int i = 0; i < 12; i++) run_vec($sformatf("rr%0d", i), vecs[i]);

      // Lock with MAX_HOLD=4: requester 2 arrives in cycle 3.
      run_vec("lock0", '{3'b001, 3'b001, 3'b000, 4'h2, 8'h22, 3'b000, 1'b0, 1'b0, 4'h0, 8'h00, 3'b000, 8'h00});
      run_vec("lock1", '{3'b001, 3'b001, 3'b000, 4'h2, 8'h22, 3'b001, 1'b1, 1'b0, 4'h1, 8'h11, 3'b000, 8'h00});
      run_vec("lock2", '{3'b001, 3'b001, 3'b000, 4'h2, 8'h22, 3'b001, 1'b1, 1'b0, 4'h1, 8'h11, 3'b001, 8'hC1});
      run_vec("lock3", '{3'b101, 3'b001, 3'b000, 4'h2, 8'h22, 3'b001, 1'b1, 1'b0, 4'h1, 8'h11, 3'b001, 8'hC1});
      run_vec("lock4", '{3'b101, 3'b001, 3'b000, 4'h2, 8'h22, 3'b001, 1'b1, 1'b0, 4'h1, 8'h11, 3'b001, 8'hC1});
      run_vec("lock5", '{3'b101, 3'b001, 3'b000, 4'h2, 8'h22, 3'b100, 1'b1, 1'b0, 4'h3, 8'h33, 3'b001, 8'hC1});
      run_vec("lock6", '{3'b101, 3'b001, 3'b000, 4'h2, 8'h22, 3'b001, 1'b1, 1'b0, 4'h1, 8'h11, 3'b100, 8'hC3});
      run_vec("lock7", '{3'b000, 3'b000, 3'b000, 4'h2, 8'h22, 3'b001, 1'b0, 1'b0, 4'h0, 8'h00, 3'b001, 8'hC1});
      run_vec("lock8", '{3'b000, 3'b000, 3'b000, 4'h2, 8'h22, 3'b000, 1'b0, 1'b0, 4'h0, 8'h00, 3'b000, 8'h00});

      // Requester 1 drops req in its first grant cycle; requester 2 takes over.
      run_vec("drop0", '{3'b010, 3'b000, 3'b000, 4'h2, 8'h22, 3'b000, 1'b0, 1'b0, 4'h0, 8'h00, 3'b000, 8'h00});
      run_vec("drop1", '{3'b100, 3'b000, 3'b000, 4'h2, 8'h22, 3'b010, 1'b0, 1'b0, 4'h0, 8'h00, 3'b000, 8'h00});
      run_vec("drop2", '{3'b100, 3'b000, 3'b000, 4'h2, 8'h22, 3'b100, 1'b1, 1'b0, 4'h3, 8'h33, 3'b000, 8'h00});
      run_vec("drop3", '{3'b000, 3'b000, 3'b000, 4'h2, 8'h22, 3'b100, 1'b0, 1'b0, 4'h0, 8'h00, 3'b100, 8'hC3});
      run_vec("drop4", '{3'b000, 3'b000, 3'b000, 4'h2, 8'h22, 3'b000, 1'b0, 1'b0, 4'h0, 8'h00, 3'b000, 8'h00});

      // Reset while requester 2 is locked and reading.
      run_vec("mrst0", '{3'b100, 3'b100, 3'b000, 4'h2, 8'h22, 3'b000, 1'b0, 1'b0, 4'h0, 8'h00, 3'b000, 8'h00});
      run_vec("mrst1", '{3'b100, 3'b100, 3'b000, 4'h2, 8'h22, 3'b100, 1'b1, 1'b0, 4'h3, 8'h33, 3'b000, 8'h00});
      run_vec("mrst2", '{3'b100, 3'b100, 3'b000, 4'h2, 8'h22, 3'b100, 1'b1, 1'b0, 4'h3, 8'h33, 3'b100, 8'hC3});
      rst_n = 1'b0;
      #1;
      check("mrst gnt",    32'(gnt),    32'h0);
      check("mrst rvalid", 32'(rvalid), 32'h0);
      check("mrst mem_cs", 32'(mem_cs), 32'h0);
      @(negedge clk);
      req   = 3'b110;
      lock  = 3'b000;
      rst_n = 1'b1;
      run_vec("mrst3", '{3'b110, 3'b000, 3'b000, 4'h2, 8'h22, 3'b010, 1'b1, 1'b0, 4'h2, 8'h22, 3'b000, 8'h00});
      run_vec("mrst4", '{3'b000, 3'b000, 3'b000, 4'h2, 8'h22, 3'b100, 1'b0, 1'b0, 4'h0, 8'h00, 3'b010, 8'hC2});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
